// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32 load/store funct3 codes,
// the responder FSM state type and a funct3 legality helper.
package mem_pkg;

  localparam int LANE_W = 8;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unused encodings are never legal; unsigned variants only exist for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
    return (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7) |
           (wr & ((f3 == F3_BU) | (f3 == F3_HU)));
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated store word,
// plus the extended load value picked out of a memory word.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_ldata
);

  logic [LANE_W-1:0] w_byte;
  logic [15:0]       w_half;

  assign w_byte = i_rword[{3'd0, i_addr_lo} * LANE_W +: LANE_W];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  // Store steering: narrow data is replicated so the enables alone choose the lane.
  always_comb begin
    o_be    = 4'b0000;
    o_wword = 32'd0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wword = 32'd0;
      end
    endcase
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    o_ldata = 32'd0;
    case (i_funct3)
      F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ldata = {24'd0, w_byte};
      F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ldata = {16'd0, w_half};
      F3_W:    o_ldata = i_rword;
      default: o_ldata = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one outstanding request, fixed-latency response, RV32 sub-word
// access on an internal word array. Optional misalignment trapping via MISALIGN_TRAP_EN.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int         DEPTH  = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_misalign;
  logic              w_err;
  logic [ADDR_W-3:0] w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wword;
  logic [31:0]       w_ldata;

  assign req_ready  = (r_state == IDLE) & ~reset;
  assign resp_valid = (r_state == RESP) & ~reset;
  assign resp_rdata = r_rdata & {32{~reset}};
  assign resp_error = r_error & ~reset;

  assign w_accept = req_valid & req_ready;
  assign w_idx    = req_addr[ADDR_W-1:2];

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = (((req_funct3 == F3_H) | (req_funct3 == F3_HU)) & req_addr[0]) |
                      ((req_funct3 == F3_W) & (req_addr[1:0] != 2'd0));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = f3_illegal(req_funct3, req_write) | w_misalign |
                 ((req_addr >> ADDR_W) != 32'd0);

  byte_lane_align u_align (
    .i_funct3  (req_funct3),
    .i_addr_lo (req_addr[1:0]),
    .i_wdata   (req_wdata),
    .i_rword   (r_mem[w_idx]),
    .o_be      (w_be),
    .o_wword   (w_wword),
    .o_ldata   (w_ldata)
  );

  // Array is deliberately not reset; stores commit on the acceptance edge.
  always_ff @(posedge clock) begin
    if (w_accept && req_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][i*LANE_W +: LANE_W] <= w_wword[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Request/response FSM with latency counter; response fields captured at acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_error <= w_err;
            r_rdata <= (w_err | req_write) ? 32'd0 : w_ldata;
            if (LATENCY <= 1) begin
              r_state <= RESP;
              r_cnt   <= 4'd0;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (r_cnt >= LAT_M1) begin
            r_state <= RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state <= IDLE;
            r_rdata <= 32'd0;
            r_error <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
